// File: rtl/uart_pkg.sv
// Shared constants, divisor layout and the default-divisor calculation for the UART baud generator.
package uart_pkg;

    localparam int unsigned MIN_DIV_INT   = 2;
    localparam int unsigned DIV_W_DEF     = 16;
    localparam int unsigned FRAC_BITS_DEF = 4;

    // Divisor in clocks per oversample tick, unsigned fixed point int.frac (default widths)
    typedef struct packed {
        logic [DIV_W_DEF-1:0]     int_part;
        logic [FRAC_BITS_DEF-1:0] frac_part;
    } baud_div_t;

    // round(clock_hz * 2^frac_bits / (baud * oversample)) in plain integer arithmetic
    function automatic longint unsigned default_div(
        input longint unsigned clock_hz,
        input longint unsigned baud,
        input longint unsigned oversample,
        input longint unsigned frac_bits
    );
        longint unsigned num;
        longint unsigned den;
        num = clock_hz << frac_bits;
        den = baud * oversample;
        return (num + (den >> 1)) / den;
    endfunction

endpackage

// File: rtl/uart_baud_gen_if.sv
// Control/status bundle between a UART datapath (master) and the baud generator (slave).
interface uart_baud_gen_if
    import uart_pkg::*;
#(
    parameter int unsigned DIV_W     = DIV_W_DEF,
    parameter int unsigned FRAC_BITS = FRAC_BITS_DEF
);

    logic                       en;
    logic                       sync;
    logic                       div_wr;
    logic [DIV_W+FRAC_BITS-1:0] div_in;
    logic [DIV_W+FRAC_BITS-1:0] div_q;
    logic                       div_pending;
    logic                       os_tick;
    logic                       bit_tick;

    modport master (
        output en, sync, div_wr, div_in,
        input  div_q, div_pending, os_tick, bit_tick
    );

    modport slave (
        input  en, sync, div_wr, div_in,
        output div_q, div_pending, os_tick, bit_tick
    );

endinterface

// File: rtl/uart_frac_div.sv
// Fractional period counter: emits os_tick every int or int+1 cycles so the mean period equals the divisor.
module uart_frac_div
    import uart_pkg::*;
#(
    parameter int unsigned       DIV_W     = DIV_W_DEF,
    parameter int unsigned       FRAC_BITS = FRAC_BITS_DEF,
    parameter logic [DIV_W-1:0]  RESET_CNT = '0
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 en,
    input  logic                 sync,
    input  logic [DIV_W-1:0]     reload_int,
    input  logic [FRAC_BITS-1:0] reload_frac,
    output logic                 os_tick
);

    logic [DIV_W-1:0]     cnt;
    logic [DIV_W-1:0]     cnt_d;
    logic [FRAC_BITS-1:0] frac_acc;
    logic [FRAC_BITS-1:0] frac_acc_d;
    logic [FRAC_BITS:0]   acc_sum;

    // Tick when the period counter expires; a restart cycle never ticks
    assign os_tick = en && !sync && (cnt == '0);
    assign acc_sum = {1'b0, frac_acc} + {1'b0, reload_frac};

    // Next counter state: restart, reload with fractional carry, or count down
    always_comb begin
        cnt_d      = cnt;
        frac_acc_d = frac_acc;
        if (sync) begin
            cnt_d      = reload_int - DIV_W'(1);
            frac_acc_d = '0;
        end else if (os_tick) begin
            frac_acc_d = acc_sum[FRAC_BITS-1:0];
            cnt_d      = reload_int + DIV_W'(acc_sum[FRAC_BITS]) - DIV_W'(1);
        end else if (en) begin
            cnt_d = cnt - DIV_W'(1);
        end
    end

    // Period counter and fractional accumulator registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt      <= RESET_CNT;
            frac_acc <= '0;
        end else begin
            cnt      <= cnt_d;
            frac_acc <= frac_acc_d;
        end
    end

endmodule

// File: rtl/uart_baud_gen.sv
// Programmable fractional baud generator: oversample strobe, bit strobe, deferred divisor update, mid-bit resync.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_HZ     = 50000000,
    parameter int unsigned DEFAULT_BAUD = 115200,
    parameter int unsigned OVERSAMPLE   = 16,
    parameter int unsigned DIV_W        = DIV_W_DEF,
    parameter int unsigned FRAC_BITS    = FRAC_BITS_DEF
) (
    input  logic          clk,
    input  logic          resetn,
    uart_baud_gen_if.slave bus
);

    localparam int unsigned DW   = DIV_W + FRAC_BITS;
    localparam int unsigned OS_W = $clog2(OVERSAMPLE);

    // Force the integer part up to the minimum usable period, keeping the fraction
    function automatic logic [DW-1:0] clamp_div(input logic [DW-1:0] d);
        logic [DIV_W-1:0] ip;
        ip = d[DW-1:FRAC_BITS];
        if (ip < DIV_W'(MIN_DIV_INT)) begin
            ip = DIV_W'(MIN_DIV_INT);
        end
        return {ip, d[FRAC_BITS-1:0]};
    endfunction

    localparam longint unsigned  DEF_RAW     = default_div(64'(CLOCK_HZ), 64'(DEFAULT_BAUD),
                                                           64'(OVERSAMPLE), 64'(FRAC_BITS));
    localparam logic [DW-1:0]    DEFAULT_DIV = clamp_div(DW'(DEF_RAW));
    localparam logic [DIV_W-1:0] RESET_CNT   = DEFAULT_DIV[DW-1:FRAC_BITS] - DIV_W'(1);

    logic [DW-1:0]   div_q;
    logic [DW-1:0]   div_d;
    logic [DW-1:0]   div_pend;
    logic [DW-1:0]   div_pend_d;
    logic            div_pending;
    logic            div_pending_d;
    logic [DW-1:0]   div_in_clamped;
    logic [OS_W-1:0] os_cnt;
    logic [OS_W-1:0] os_cnt_d;
    logic            os_tick;
    logic            bit_tick;

    assign div_in_clamped = clamp_div(bus.div_in);
    assign bit_tick       = os_tick && (os_cnt == OS_W'(OVERSAMPLE - 1));

    // Divisor in effect next cycle; also the value the period counter reloads with this cycle
    always_comb begin
        div_d         = div_q;
        div_pend_d    = div_pend;
        div_pending_d = div_pending;
        if (bit_tick && div_pending) begin
            div_d         = div_pend;
            div_pending_d = 1'b0;
        end
        if (bus.div_wr) begin
            if (!bus.en || bus.sync) begin
                div_d         = div_in_clamped;
                div_pending_d = 1'b0;
            end else begin
                div_pend_d    = div_in_clamped;
                div_pending_d = 1'b1;
            end
        end
    end

    // Oversample index: restart lands the next bit strobe at half a bit
    always_comb begin
        os_cnt_d = os_cnt;
        if (bus.sync) begin
            os_cnt_d = OS_W'(OVERSAMPLE / 2);
        end else if (os_tick) begin
            os_cnt_d = os_cnt + OS_W'(1);
        end
    end

    // Divisor, pending divisor and oversample index registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_q       <= DEFAULT_DIV;
            div_pend    <= DEFAULT_DIV;
            div_pending <= 1'b0;
            os_cnt      <= '0;
        end else begin
            div_q       <= div_d;
            div_pend    <= div_pend_d;
            div_pending <= div_pending_d;
            os_cnt      <= os_cnt_d;
        end
    end

    uart_frac_div #(
        .DIV_W     (DIV_W),
        .FRAC_BITS (FRAC_BITS),
        .RESET_CNT (RESET_CNT)
    ) u_frac_div (
        .clk         (clk),
        .resetn      (resetn),
        .en          (bus.en),
        .sync        (bus.sync),
        .reload_int  (div_d[DW-1:FRAC_BITS]),
        .reload_frac (div_d[FRAC_BITS-1:0]),
        .os_tick     (os_tick)
    );

    assign bus.div_q       = div_q;
    assign bus.div_pending = div_pending;
    assign bus.os_tick     = os_tick;
    assign bus.bit_tick    = bit_tick;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Scoreboard bench for uart_baud_gen against an ideal fixed-point tick timeline model.
module tb_uart_baud_gen;
    import uart_pkg::*;

    localparam int unsigned F  = 4;
    localparam int unsigned OS = 16;
    localparam int unsigned DW = 20;

    typedef struct {
        bit            os;
        bit            bt;
        logic [DW-1:0] dq;
        bit            pend;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    uart_baud_gen_if #(.DIV_W(16), .FRAC_BITS(F)) bus ();

    uart_baud_gen #(
        .CLOCK_HZ     (50000000),
        .DEFAULT_BAUD (115200),
        .OVERSAMPLE   (OS),
        .DIV_W        (16),
        .FRAC_BITS    (F)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;

    logic [DW-1:0] def_div;

    // Reference model: next tick position on an ideal timeline in 1/2^F units of active cycles
    longint        m_a;
    longint        m_ideal;
    int            m_n;
    int            m_off;
    logic [DW-1:0] m_dq;
    logic [DW-1:0] m_dp;
    bit            m_pend;

    task automatic chk(input string nm, input longint act, input longint expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, expv);
    endtask

    function automatic logic [DW-1:0] clamp_model(input logic [DW-1:0] d);
        baud_div_t v;
        v = d;
        if (v.int_part < 16'(MIN_DIV_INT)) v.int_part = 16'(MIN_DIV_INT);
        return v;
    endfunction

    function automatic longint int_of(input logic [DW-1:0] d);
        return longint'(d) / longint'(1 << F);
    endfunction

    task automatic model_reset();
        m_a     = 0;
        m_dq    = def_div;
        m_dp    = def_div;
        m_pend  = 0;
        m_ideal = (int_of(m_dq) - 1) * longint'(1 << F);
        m_n     = 0;
        m_off   = 0;
    endtask

    task automatic model_cycle(input bit rn, input bit e, input bit s, input bit w,
                               input logic [DW-1:0] d);
        exp_t          x;
        bit            tk;
        logic [DW-1:0] cw;
        x.cyc = cyc;
        if (!rn) begin
            model_reset();
            x.os = 0; x.bt = 0; x.dq = def_div; x.pend = 0;
            exp_q.push_back(x);
            return;
        end
        tk     = e && !s && (m_a == m_ideal / longint'(1 << F));
        x.os   = tk;
        x.bt   = tk && (((m_off + m_n) % OS) == OS - 1);
        x.dq   = m_dq;
        x.pend = m_pend;
        exp_q.push_back(x);
        cw = clamp_model(d);
        if (s) begin
            if (w) begin m_dq = cw; m_pend = 0; end
            m_ideal = (m_a + int_of(m_dq) - 1) * longint'(1 << F);
            m_n     = 0;
            m_off   = OS / 2;
        end else if (e) begin
            if (tk) begin
                if (x.bt && m_pend) begin m_dq = m_dp; m_pend = 0; end
                m_ideal += longint'(m_dq);
                m_n++;
            end
            m_a++;
            if (w) begin m_dp = cw; m_pend = 1; end
        end else if (w) begin
            m_dq = cw; m_pend = 0;
        end
    endtask

    task automatic step(input bit rn, input bit e, input bit s, input bit w, input logic [DW-1:0] d);
        @(posedge clk);
        #1;
        resetn     = rn;
        bus.en     = e;
        bus.sync   = s;
        bus.div_wr = w;
        bus.div_in = d;
        model_cycle(rn, e, s, w, d);
        cyc++;
    endtask

    task automatic run(input int n, input bit e);
        for (int i = 0; i < n; i++) step(1, e, 0, 0, '0);
    endtask

    // Monitor: every cycle the DUT presents outputs, compare against the oldest expectation
    initial begin : monitor
        exp_t x;
        int   last_tick;
        last_tick = -100;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("outputs{os,bit,pend,div_q}",
                    {bus.os_tick, bus.bit_tick, bus.div_pending, bus.div_q},
                    {x.os, x.bt, x.pend, x.dq});
                if (bus.os_tick === 1'b1) begin
                    if (last_tick >= 0) chk("os_tick_spacing_ge2", longint'(x.cyc - last_tick >= 2), 1);
                    last_tick = x.cyc;
                end
            end
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        bit            e, s, w, rn;
        logic [DW-1:0] d;
        def_div = DW'($rtoi(50000000.0 * 16.0 / (115200.0 * 16.0) + 0.5));
        model_reset();
        bus.en = 0; bus.sync = 0; bus.div_wr = 0; bus.div_in = '0;

        // Reset, then free-run at the default rate
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, '0);
        #1;
        chk("reset_div_q", bus.div_q, 434);
        chk("reset_pending", bus.div_pending, 0);
        run(900, 1);

        // Mid-bit divisor write deferred to the next bit strobe
        step(1, 1, 0, 1, 20'h00020);
        step(1, 1, 0, 0, '0);
        chk("pending_after_write", bus.div_pending, 1);
        run(600, 1);
        chk("div_q_after_apply", bus.div_q, 20'h00020);
        chk("pending_cleared", bus.div_pending, 0);
        step(1, 1, 0, 1, 20'd434);
        run(100, 1);

        // Resync at an arbitrary phase
        run($urandom_range(0, 400), 1);
        step(1, 1, 1, 0, '0);
        run(900, 1);

        // Stall mid-period
        run(100, 1);
        run(50, 0);
        run(500, 1);

        // Integer part below minimum is clamped
        step(1, 1, 0, 1, 20'h00013);
        run(500, 1);
        chk("clamped_div_q", bus.div_q, 20'h00023);

        // Write together with sync takes effect immediately
        step(1, 1, 1, 1, 20'h00020);
        step(1, 1, 0, 0, '0);
        chk("sync_write_div_q", bus.div_q, 20'h00020);
        chk("sync_write_pending", bus.div_pending, 0);
        run(60, 1);

        // Reset with a write pending
        step(1, 1, 0, 1, 20'd434);
        step(1, 1, 0, 0, '0);
        chk("pending_before_reset", bus.div_pending, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, '0);
        #1;
        chk("midreset_div_q", bus.div_q, 434);
        chk("midreset_pending", bus.div_pending, 0);
        chk("midreset_ticks", {bus.os_tick, bus.bit_tick}, 0);
        run(900, 1);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            rn = ($urandom_range(0, 999) != 0);
            e  = ($urandom_range(0, 9) != 0);
            s  = ($urandom_range(0, 199) == 0);
            w  = ($urandom_range(0, 149) == 0);
            d  = {16'($urandom_range(0, 5)), 4'($urandom_range(0, 15))};
            step(rn, e, s, w, d);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_baud_gen.md
Name: uart_baud_gen

Overview:
Runtime-programmable fractional baud generator for the UART TX/RX paths. Produces a 1-cycle oversample strobe (os_tick) and a 1-cycle bit strobe (bit_tick) every OVERSAMPLE oversample ticks. The divisor has FRAC_BITS fractional bits, so non-integer clock/baud ratios carry no cumulative drift. RX uses sync to re-phase the bit strobe to mid-bit on a start-bit edge.

Parameters:
CLOCK_HZ, 50000000, input clock frequency in Hz.
DEFAULT_BAUD, 115200, baud rate loaded at reset.
OVERSAMPLE, 16, oversample ticks per bit; power of two, ≥4.
DIV_W, 16, integer bits of the divisor.
FRAC_BITS, 4, fractional bits of the divisor.

Ports:
clk  in  1  clock
resetn  in  1  reset, asynchronous, active-low
en  in  1  count enable; low freezes all counters and suppresses ticks
sync  in  1  1-cycle pulse: restart phase, next bit_tick lands at half-bit
div_wr  in  1  write strobe for div_in
div_in  in  DIV_W+FRAC_BITS  clocks per os_tick, unsigned fixed-point, int.frac
div_q  out  DIV_W+FRAC_BITS  divisor currently in effect
div_pending  out  1  written divisor not yet applied
os_tick  out  1  oversample strobe
bit_tick  out  1  bit strobe

Behaviour:
- DEFAULT_DIV = round(CLOCK_HZ·2^FRAC_BITS / (DEFAULT_BAUD·OVERSAMPLE)). With the defaults this is 434, i.e. int 27, frac 2.
- Reset state: div_q = DEFAULT_DIV, div_pending = 0, os_cnt = 0, frac_acc = 0, cnt = int(DEFAULT_DIV)−1. Ticks are 0 while in reset.
- Integer part clamp: on write and at parameter elaboration, any integer part <2 is forced to 2 (fraction is kept).
- os_tick = en && cnt==0. This is combinational from registers, with no added latency.
- bit_tick = os_tick && os_cnt==OVERSAMPLE−1.
- On os_tick:
  - {carry, frac_acc} ← frac_acc + frac(div_q), FRAC_BITS-wide and wrapping.
  - cnt ← int(div_q) + carry − 1.
  - os_cnt ← os_cnt+1, wrapping at OVERSAMPLE.
  - Result: spacing is int or int+1 cycles, and the mean spacing equals div exactly over 2^FRAC_BITS ticks.
- When en is high and there is no tick, cnt decrements.
- When en is low, cnt, os_cnt and frac_acc hold and the ticks stay 0. div_wr still applies immediately while en is low.
- div_wr handling:
  - div_in (after clamp) is captured into div_pend and div_pending=1.
  - The pending value is applied in the cycle bit_tick is high: div_q ← div_pend and div_pending ← 0. The new divisor governs the reload made on that same tick.
  - If en=0 or sync=1 in the write cycle, it is applied immediately instead.
  - A second write before application overwrites div_pend.
- sync has priority over counting:
  - cnt ← int(div_q)−1, frac_acc ← 0, os_cnt ← OVERSAMPLE/2.
  - Ticks are forced to 0 in the sync cycle. This holds regardless of en.
  - Consequence: bit_tick comes exactly OVERSAMPLE/2 os_ticks after sync.
- Simultaneous div_wr and sync: the new div is applied and used for the sync reload.
- Asserting resetn mid-operation returns everything to reset values at once. A pending write is discarded.

Decomposition:
- Package uart_pkg holds:
  - function default_div(CLOCK_HZ, BAUD, OVERSAMPLE, FRAC_BITS);
  - constant MIN_DIV_INT = 2;
  - typedef for the divisor struct {int, frac}.
- Sub-module uart_frac_div contains the fractional period counter (cnt, frac_acc, reload, sync restart) and emits os_tick.
- The top level holds os_cnt, the pending-divisor register, the clamp and bit_tick.

Test Plan:
- Defaults, release reset with en=1:
  - first os_tick at cycle 26 (cycle 0 = first cycle after release), i.e. 27 cycles;
  - spacings 27×7 then 28, repeating;
  - bit_tick every 434 cycles;
  - div_q=434.
- Mid-bit write div_in=0x0020 (int 2, frac 0):
  - div_pending=1 until the next bit_tick;
  - after that bit_tick, os_tick every 2 cycles and bit_tick every 32;
  - div_pending=0.
- Pulse sync at arbitrary phase with div=434:
  - no tick in the sync cycle;
  - next os_tick 27 cycles later;
  - bit_tick 216 cycles after sync;
  - subsequent bit_ticks every 434 cycles.
- en low for 50 cycles mid-period:
  - no ticks;
  - the next os_tick is delayed by exactly 50 cycles versus an unstalled run.
- Write div_in=0x0013 (int 1, frac 3):
  - div_q reads 0x0023 after application;
  - os_tick spacing ≥2.
- Write div_in=0x0020 and pulse sync in the same cycle:
  - div_q=0x0020 immediately;
  - bit_tick 16 cycles after sync.
- Assert resetn low with a write pending:
  - div_q=434, div_pending=0, ticks 0.
  - After release, timing is identical to the first scenario.
